// File: rtl/alarm_bank.sv
// Multi-channel BCD alarm store with ring/snooze/stop controller.
// Define ALARM_ONESHOT_EN to add per-channel one-shot alarms (wr_once/rd_once).
module alarm_bank #(
  parameter int NUM_ALARMS = 4,
  parameter int ID_W       = 2,
  parameter int SNOOZE_MIN = 5,
  parameter int RING_MIN   = 3,
  parameter int MAX_SNOOZE = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tick_min,
  input  logic [3:0]      cur_h1,
  input  logic [3:0]      cur_h0,
  input  logic [3:0]      cur_m1,
  input  logic [3:0]      cur_m0,
  input  logic            wr_en,
  input  logic [ID_W-1:0] wr_sel,
  input  logic [3:0]      wr_h1,
  input  logic [3:0]      wr_h0,
  input  logic [3:0]      wr_m1,
  input  logic [3:0]      wr_m0,
  input  logic            wr_arm,
`ifdef ALARM_ONESHOT_EN
  input  logic            wr_once,
  output logic            rd_once,
`endif
  output logic            wr_err,
  input  logic [ID_W-1:0] rd_sel,
  output logic [3:0]      rd_h1,
  output logic [3:0]      rd_h0,
  output logic [3:0]      rd_m1,
  output logic [3:0]      rd_m0,
  output logic            rd_arm,
  input  logic            snooze,
  input  logic            stop,
  output logic            ring,
  output logic [ID_W-1:0] ring_id,
  output logic            snoozed
);

  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

  state_t                state, state_nxt;
  logic [3:0]            al_h1 [NUM_ALARMS];
  logic [3:0]            al_h0 [NUM_ALARMS];
  logic [3:0]            al_m1 [NUM_ALARMS];
  logic [3:0]            al_m0 [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] arm;
`ifdef ALARM_ONESHOT_EN
  logic [NUM_ALARMS-1:0] once;
`endif
  logic [3:0]            ring_cnt, ring_cnt_nxt;
  logic [3:0]            nap_cnt, nap_cnt_nxt;
  logic [2:0]            snz_cnt, snz_cnt_nxt;
  logic [ID_W-1:0]       ring_id_nxt;
  logic [ID_W-1:0]       win_id;
  logic                  hit, fire, wr_bad;

  always_comb begin
    wr_bad = (int'(wr_sel) >= NUM_ALARMS) || (wr_m1 > 4'd5) || (wr_m0 > 4'd9) ||
             (wr_h1 > 4'd2) || (wr_h0 > 4'd9) || ((wr_h1 == 4'd2) && (wr_h0 > 4'd3));
  end

  // Scan high to low so the lowest matching channel is the last assignment
  always_comb begin
    hit    = 1'b0;
    win_id = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (arm[i] && al_h1[i] == cur_h1 && al_h0[i] == cur_h0 &&
          al_m1[i] == cur_m1 && al_m0[i] == cur_m0) begin
        hit    = 1'b1;
        win_id = ID_W'(i);
      end
    end
  end

  always_comb begin
    rd_h1  = '0;
    rd_h0  = '0;
    rd_m1  = '0;
    rd_m0  = '0;
    rd_arm = 1'b0;
`ifdef ALARM_ONESHOT_EN
    rd_once = 1'b0;
`endif
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (rd_sel == ID_W'(i)) begin
        rd_h1  = al_h1[i];
        rd_h0  = al_h0[i];
        rd_m1  = al_m1[i];
        rd_m0  = al_m0[i];
        rd_arm = arm[i];
`ifdef ALARM_ONESHOT_EN
        rd_once = once[i];
`endif
      end
    end
  end

  // Alarm store; the match above always sees pre-write contents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        al_h1[i] <= '0;
        al_h0[i] <= '0;
        al_m1[i] <= '0;
        al_m0[i] <= '0;
      end
      arm    <= '0;
`ifdef ALARM_ONESHOT_EN
      once   <= '0;
`endif
      wr_err <= 1'b0;
    end else begin
      wr_err <= wr_en && wr_bad;
      for (int i = 0; i < NUM_ALARMS; i++) begin
`ifdef ALARM_ONESHOT_EN
        if (fire && once[i] && win_id == ID_W'(i)) arm[i] <= 1'b0;
`endif
        if (wr_en && !wr_bad && wr_sel == ID_W'(i)) begin
          al_h1[i] <= wr_h1;
          al_h0[i] <= wr_h0;
          al_m1[i] <= wr_m1;
          al_m0[i] <= wr_m0;
          arm[i]   <= wr_arm;
`ifdef ALARM_ONESHOT_EN
          once[i]  <= wr_once;
`endif
        end
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    ring_cnt_nxt = ring_cnt;
    nap_cnt_nxt  = nap_cnt;
    snz_cnt_nxt  = snz_cnt;
    ring_id_nxt  = ring_id;
    fire         = 1'b0;
    case (state)
      IDLE: begin
        if (tick_min && hit) begin
          state_nxt    = RING;
          ring_cnt_nxt = '0;
          snz_cnt_nxt  = '0;
          ring_id_nxt  = win_id;
          fire         = 1'b1;
        end
      end
      RING: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (snooze && snz_cnt < 3'(MAX_SNOOZE)) begin
          state_nxt   = SNOOZE;
          nap_cnt_nxt = 4'(SNOOZE_MIN);
          snz_cnt_nxt = snz_cnt + 3'd1;
        end else if (tick_min) begin
          ring_cnt_nxt = ring_cnt + 4'd1;
          if (ring_cnt + 4'd1 == 4'(RING_MIN)) state_nxt = IDLE;
        end
      end
      SNOOZE: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (tick_min) begin
          nap_cnt_nxt = nap_cnt - 4'd1;
          if (nap_cnt == 4'd1) begin
            state_nxt    = RING;
            ring_cnt_nxt = '0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ring_cnt <= '0;
      nap_cnt  <= '0;
      snz_cnt  <= '0;
      ring_id  <= '0;
      ring     <= 1'b0;
      snoozed  <= 1'b0;
    end else begin
      state    <= state_nxt;
      ring_cnt <= ring_cnt_nxt;
      nap_cnt  <= nap_cnt_nxt;
      snz_cnt  <= snz_cnt_nxt;
      ring_id  <= ring_id_nxt;
      ring     <= (state_nxt == RING);
      snoozed  <= (state_nxt == SNOOZE);
    end
  end

endmodule

// File: tb/tb_alarm_bank.sv
// Scoreboard bench for alarm_bank: expected {ring,snoozed,ring_id,wr_err} queued per stimulus cycle.
module tb_alarm_bank;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_min = 1'b0;
  logic [3:0] cur_h1 = '0, cur_h0 = '0, cur_m1 = '0, cur_m0 = '0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_sel = '0;
  logic [3:0] wr_h1 = '0, wr_h0 = '0, wr_m1 = '0, wr_m0 = '0;
  logic       wr_arm = 1'b0;
  logic       wr_err;
  logic [1:0] rd_sel = '0;
  logic [3:0] rd_h1, rd_h0, rd_m1, rd_m0;
  logic       rd_arm;
  logic       snooze = 1'b0;
  logic       stop = 1'b0;
  logic       ring;
  logic [1:0] ring_id;
  logic       snoozed;
`ifdef ALARM_ONESHOT_EN
  logic       wr_once = 1'b0;
  logic       rd_once;
`endif

  int vecs = 0;
  int errs = 0;
  logic [4:0] exp_q[$];
  logic [4:0] e;
  logic [4:0] st;
  logic [16:0] rd;

  assign st = {ring, snoozed, ring_id, wr_err};
  assign rd = {rd_h1, rd_h0, rd_m1, rd_m0, rd_arm};

  alarm_bank #(.NUM_ALARMS(4), .ID_W(2), .SNOOZE_MIN(5), .RING_MIN(3), .MAX_SNOOZE(3)) dut (
    .clk(clk), .rst_n(rst_n), .tick_min(tick_min),
    .cur_h1(cur_h1), .cur_h0(cur_h0), .cur_m1(cur_m1), .cur_m0(cur_m0),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_h1(wr_h1), .wr_h0(wr_h0),
    .wr_m1(wr_m1), .wr_m0(wr_m0), .wr_arm(wr_arm),
`ifdef ALARM_ONESHOT_EN
    .wr_once(wr_once), .rd_once(rd_once),
`endif
    .wr_err(wr_err), .rd_sel(rd_sel),
    .rd_h1(rd_h1), .rd_h0(rd_h0), .rd_m1(rd_m1), .rd_m0(rd_m0), .rd_arm(rd_arm),
    .snooze(snooze), .stop(stop), .ring(ring), .ring_id(ring_id), .snoozed(snoozed)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] sel, input logic [3:0] h1, h0, m1, m0,
                    input logic arm_b, input logic once_b);
    wr_sel = sel; wr_h1 = h1; wr_h0 = h0; wr_m1 = m1; wr_m0 = m0; wr_arm = arm_b;
`ifdef ALARM_ONESHOT_EN
    wr_once = once_b;
`endif
    wr_en = 1'b1;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic tick(input logic [3:0] h1, h0, m1, m0);
    cur_h1 = h1; cur_h0 = h0; cur_m1 = m1; cur_m0 = m0;
    tick_min = 1'b1;
    cyc();
    tick_min = 1'b0;
  endtask

  task automatic user(input logic snz, input logic stp, input logic tck);
    snooze = snz; stop = stp; tick_min = tck;
    cyc();
    snooze = 1'b0; stop = 1'b0; tick_min = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    exp_q.push_back(5'b00000);
    cyc();
    e = exp_q.pop_front(); vecs++;
    if (st !== e) begin errs++; $display("FAIL reset_status got %b want %b", st, e); end
    for (int i = 0; i < 4; i++) begin
      rd_sel = 2'(i); #1; vecs++;
      if (rd !== 17'd0) begin errs++; $display("FAIL reset_rd ch%0d got %h want 0", i, rd); end
    end
  endtask

  task automatic test_match();
    exp_q.push_back(5'b00000);
    wr(2'd1, 4'd0, 4'd7, 4'd3, 4'd0, 1'b1, 1'b0);
    e = exp_q.pop_front(); vecs++;
    if (st !== e) begin errs++; $display("FAIL write_ok got %b want %b", st, e); end
    exp_q.push_back(5'b10010);
    tick(4'd0, 4'd7, 4'd3, 4'd0);
    e = exp_q.pop_front(); vecs++;
    if (st !== e) begin errs++; $display("FAIL match_ring got %b want %b", st, e); end
    rd_sel = 2'd1; #1; vecs++;
    if (rd !== {4'd0, 4'd7, 4'd3, 4'd0, 1'b1}) begin errs++; $display("FAIL rd_ch1 got %h want %h", rd, {4'd0, 4'd7, 4'd3, 4'd0, 1'b1}); end
    exp_q.push_back(5'b00010);
    user(1'b0, 1'b1, 1'b0);
    e = exp_q.pop_front(); vecs++;
    if (st !== e) begin errs++; $display("FAIL stop_idle got %b want %b", st, e); end
  endtask

  task automatic test_write_reject();
    exp_q.push_back(5'b00011);
    wr(2'd1, 4'd0, 4'd7, 4'd6, 4'd0, 1'b1, 1'b0);
    exp_q.push_back(5'b00010);
    e = exp_q.pop_front(); vecs++;
    if (st !== e) begin errs++; $display("FAIL rej_m1 got %b want %b", st, e); end
    cyc();
    e = exp_q.pop_front(); vecs++;
    if (st !== e) begin errs++; $display("FAIL err_one_cycle got %b want %b", st, e); end
    rd_sel = 2'd1; #1; vecs++;
    if (rd !== {4'd0, 4'd7, 4'd3, 4'd0, 1'b1}) begin errs++; $display("FAIL rej_rd_ch1 got %h", rd); end
    exp_q.push_back(5'b00011);
    wr(2'd2, 4'd2, 4'd4, 4'd0, 4'd0, 1'b1, 1'b0);
    e = exp_q.pop_front(); vecs++;
    if (st !== e) begin errs++; $display("FAIL rej_h24 got %b want %b", st, e); end
    rd_sel = 2'd2; #1; vecs++;
    if (rd !== 17'd0) begin errs++; $display("FAIL rej_rd_ch2 got %h want 0", rd); end
    exp_q.push_back(5'b00010);
    wr(2'd2, 4'd2, 4'd3, 4'd5, 4'd9, 1'b1, 1'b0);
    e = exp_q.pop_front(); vecs++;
    if (st !== e) begin errs++; $display("FAIL acc_2359 got %b want %b", st, e); end
    rd_sel = 2'd2; #1; vecs++;
    if (rd !== {4'd2, 4'd3, 4'd5, 4'd9, 1'b1}) begin errs++; $display("FAIL rd_2359 got %h", rd); end
  endtask

  task automatic test_priority_timeout();
    wr(2'd0, 4'd0, 4'd6, 4'd0, 4'd0, 1'b1, 1'b0);
    wr(2'd2, 4'd0, 4'd6, 4'd0, 4'd0, 1'b1, 1'b0);
    exp_q.push_back(5'b10000);
    exp_q.push_back(5'b10000);
    exp_q.push_back(5'b10000);
    exp_q.push_back(5'b00000);
    for (int k = 0; k < 4; k++) begin
      tick(4'd0, 4'd6, 4'd0, 4'(k));
      e = exp_q.pop_front(); vecs++;
      if (st !== e) begin errs++; $display("FAIL prio_timeout step%0d got %b want %b", k, st, e); end
    end
  endtask

  task automatic test_snooze();
    exp_q.push_back(5'b10000);
    tick(4'd0, 4'd6, 4'd0, 4'd0);
    e = exp_q.pop_front(); vecs++;
    if (st !== e) begin errs++; $display("FAIL snz_ring got %b want %b", st, e); end
    for (int n = 0; n < 3; n++) begin
      exp_q.push_back(5'b01000);
      user(1'b1, 1'b0, 1'b0);
      e = exp_q.pop_front(); vecs++;
      if (st !== e) begin errs++; $display("FAIL snz_enter n%0d got %b want %b", n, st, e); end
      for (int t = 0; t < 5; t++) begin
        exp_q.push_back(t == 4 ? 5'b10000 : 5'b01000);
        tick(4'd0, 4'd7, 4'd3, 4'd0);
        e = exp_q.pop_front(); vecs++;
        if (st !== e) begin errs++; $display("FAIL snz_nap n%0d t%0d got %b want %b", n, t, st, e); end
      end
    end
    exp_q.push_back(5'b10000);
    user(1'b1, 1'b0, 1'b0);
    e = exp_q.pop_front(); vecs++;
    if (st !== e) begin errs++; $display("FAIL snz_limit got %b want %b", st, e); end
    exp_q.push_back(5'b00000);
    user(1'b0, 1'b1, 1'b0);
    e = exp_q.pop_front(); vecs++;
    if (st !== e) begin errs++; $display("FAIL snz_stop got %b want %b", st, e); end
  endtask

  task automatic test_simultaneous_reset();
    exp_q.push_back(5'b00000);
    user(1'b1, 1'b1, 1'b0);
    e = exp_q.pop_front(); vecs++;
    if (st !== e) begin errs++; $display("FAIL idle_ignore got %b want %b", st, e); end
    tick(4'd0, 4'd6, 4'd0, 4'd0);
    exp_q.push_back(5'b00000);
    user(1'b1, 1'b1, 1'b0);
    e = exp_q.pop_front(); vecs++;
    if (st !== e) begin errs++; $display("FAIL stop_beats_snooze got %b want %b", st, e); end
    tick(4'd0, 4'd6, 4'd0, 4'd0);
    cur_m0 = 4'd1;
    exp_q.push_back(5'b01000);
    user(1'b1, 1'b0, 1'b1);
    e = exp_q.pop_front(); vecs++;
    if (st !== e) begin errs++; $display("FAIL snooze_beats_tick got %b want %b", st, e); end
    for (int t = 0; t < 5; t++) begin
      exp_q.push_back(t == 4 ? 5'b10000 : 5'b01000);
      tick(4'd0, 4'd6, 4'd0, 4'd2);
      e = exp_q.pop_front(); vecs++;
      if (st !== e) begin errs++; $display("FAIL nap_full t%0d got %b want %b", t, st, e); end
    end
    exp_q.push_back(5'b01000);
    user(1'b1, 1'b0, 1'b0);
    e = exp_q.pop_front(); vecs++;
    if (st !== e) begin errs++; $display("FAIL pre_reset_snz got %b want %b", st, e); end
    #2 rst_n = 1'b0;
    #1;
    exp_q.push_back(5'b00000);
    e = exp_q.pop_front(); vecs++;
    if (st !== e) begin errs++; $display("FAIL async_reset got %b want %b", st, e); end
    for (int i = 0; i < 4; i++) begin
      rd_sel = 2'(i); #1; vecs++;
      if (rd_arm !== 1'b0) begin errs++; $display("FAIL reset_arm ch%0d got %b want 0", i, rd_arm); end
    end
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

`ifdef ALARM_ONESHOT_EN
  task automatic test_oneshot();
    wr(2'd3, 4'd0, 4'd8, 4'd0, 4'd0, 1'b1, 1'b1);
    exp_q.push_back(5'b10110);
    tick(4'd0, 4'd8, 4'd0, 4'd0);
    e = exp_q.pop_front(); vecs++;
    if (st !== e) begin errs++; $display("FAIL once_ring got %b want %b", st, e); end
    rd_sel = 2'd3; #1; vecs++;
    if (rd_arm !== 1'b0) begin errs++; $display("FAIL once_disarm got %b want 0", rd_arm); end
    user(1'b0, 1'b1, 1'b0);
    exp_q.push_back(5'b00110);
    tick(4'd0, 4'd8, 4'd0, 4'd0);
    e = exp_q.pop_front(); vecs++;
    if (st !== e) begin errs++; $display("FAIL once_next_day got %b want %b", st, e); end
  endtask
`endif

  initial begin
    test_reset();
    test_match();
    test_write_reject();
    test_priority_timeout();
    test_snooze();
    test_simultaneous_reset();
`ifdef ALARM_ONESHOT_EN
    test_oneshot();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
